// File: rtl/seg7_pkg.sv
// Shared types and nibble-to-segment encodings for the 7-segment scan controller.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segment pattern, bit order g..a (bit 6 = g, bit 0 = a).
  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational hex nibble to active-low 7-segment decoder, shared by all digits.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n_c
);

  always_comb begin
    seg_n_c = seg7_encode(nibble);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller with frame-aligned commit.
// Optional LEADING_ZERO_BLANK_EN: darkens leading-zero digits above digit 0.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  output logic                    load_ack,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_sel_n
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_t           state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [VAL_W-1:0]      shadow, shadow_nxt;
  logic [VAL_W-1:0]      pend_val, pend_val_nxt;
  logic                  pending, pending_nxt;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;
  logic                  ack_nxt;

  logic [3:0]            nibble;
  logic                  en_cur;
  logic                  lz_dark;
  logic                  show;
  logic                  commit;
  logic [6:0]            lut_seg_n_c;

  // Select the active digit's nibble and enable for the single shared decoder.
  always_comb begin
    nibble = 4'h0;
    en_cur = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble = shadow[4*i +: 4];
        en_cur = digit_en[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // A digit above 0 is dark when it and every more-significant nibble are zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_dark    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (shadow[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        lz_dark = upper_zero;
      end
    end
  end
`else
  assign lz_dark = 1'b0;
`endif

  seg7_lut u_lut (
    .nibble  (nibble),
    .seg_n_c (lut_seg_n_c)
  );

  assign show = (state == DRIVE) && en_cur && !lz_dark;

  // Slot sequencing, frame-boundary commit and next output values.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + CNT_W'(1);
    idx_nxt      = idx;
    commit       = 1'b0;
    pend_val_nxt = pend_val;
    pending_nxt  = pending;
    shadow_nxt   = shadow;
    seg_nxt      = SEG_OFF;
    sel_nxt      = '1;
    ack_nxt      = 1'b0;

    case (state)
      BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == CNT_W'(PRESCALE - 1)) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          if (idx == IDX_W'(NUM_DIGITS - 1)) begin
            idx_nxt = '0;
            commit  = pending;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase

    // Commit takes the value pending before this cycle; a same-cycle load stays pending.
    if (commit) begin
      shadow_nxt  = pend_val;
      pending_nxt = 1'b0;
      ack_nxt     = 1'b1;
    end
    if (load) begin
      pend_val_nxt = value_in;
      pending_nxt  = 1'b1;
    end

    if (show) begin
      seg_nxt = lut_seg_n_c;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IDX_W'(i)) begin
          sel_nxt[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BLANK;
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      pend_val  <= '0;
      pending   <= 1'b0;
      seg_n     <= SEG_OFF;
      dig_sel_n <= '1;
      load_ack  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shadow    <= shadow_nxt;
      pend_val  <= pend_val_nxt;
      pending   <= pending_nxt;
      seg_n     <= seg_nxt;
      dig_sel_n <= sel_nxt;
      load_ack  <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
module tb_seg7_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned PS = 8;
  localparam int unsigned BC = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  digit_en;
  logic [6:0]  seg_n;
  logic [3:0]  dig_sel_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      en;
    logic [3:0][6:0] seg;
    logic [3:0]      lit;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .PRESCALE     (PS),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value_in  (value_in),
    .load      (load),
    .load_ack  (load_ack),
    .digit_en  (digit_en),
    .seg_n     (seg_n),
    .dig_sel_n (dig_sel_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Invariants on every cycle: at most one select low; all selects high implies blank segments.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("onehot_sel", 32'($countones(~dig_sel_n) <= 1), 32'd1);
      if (&dig_sel_n) check("dark_seg", 32'(seg_n), 32'h7F);
    end
  end

  task automatic wait_ack(input string name, input int limit, output int cyc, output bit seen79);
    cyc    = -1;
    seen79 = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (dig_sel_n != 4'hF && seg_n == 7'h79) seen79 = 1'b1;
      if (load_ack === 1'b1) begin
        cyc = i;
        break;
      end
    end
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL %s: no load_ack within %0d cycles", name, limit);
    end
  endtask

  // Called right after the commit cycle: checks all 32 cycles of the following frame.
  task automatic capture_frame(input string name, input vec_t v);
    int slot, off;
    logic [3:0] exp_sel;
    logic [6:0] exp_seg;
    for (int k = 1; k <= 32; k++) begin
      step();
      slot    = (k - 1) / 8;
      off     = (k - 1) % 8;
      exp_sel = 4'hF;
      exp_seg = 7'h7F;
      if (off >= 2 && v.lit[slot]) begin
        exp_sel[slot] = 1'b0;
        exp_seg       = v.seg[slot];
      end
      check($sformatf("%s_sel_k%0d", name, k), 32'(dig_sel_n), 32'(exp_sel));
      check($sformatf("%s_seg_k%0d", name, k), 32'(seg_n), 32'(exp_seg));
      check($sformatf("%s_ack_k%0d", name, k), 32'(load_ack), 32'd0);
    end
  endtask

  initial begin
    int   cyc;
    bit   seen79;
    int   bad;
    int   acks;
    vec_t v;

    tbl[0] = '{16'h1A3F, 4'hF,    {7'h79, 7'h08, 7'h30, 7'h0E}, 4'hF};
    tbl[1] = '{16'h5A5A, 4'b0101, {7'h12, 7'h08, 7'h12, 7'h08}, 4'b0101};
    tbl[2] = '{16'h0050, 4'hF,    {7'h40, 7'h40, 7'h12, 7'h40}, LZB ? 4'b0011 : 4'hF};
    tbl[3] = '{16'h0000, 4'hF,    {7'h40, 7'h40, 7'h40, 7'h40}, LZB ? 4'b0001 : 4'hF};
    tbl[4] = '{16'h8C6D, 4'hF,    {7'h00, 7'h46, 7'h02, 7'h21}, 4'hF};
    tbl[5] = '{16'h9B74, 4'b1010, {7'h10, 7'h03, 7'h78, 7'h19}, 4'b1010};
    tbl[6] = '{16'h0E00, 4'hF,    {7'h40, 7'h06, 7'h40, 7'h40}, LZB ? 4'b0111 : 4'hF};

    reset    = 1'b1;
    load     = 1'b0;
    value_in = 16'h0;
    digit_en = 4'hF;
    step();
    step();
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_sel", 32'(dig_sel_n), 32'hF);
    check("rst_ack", 32'(load_ack), 32'd0);

    // Reset release: 2 blank cycles, then digit 0 shows 0 for cycles 3..8.
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k <= 2 || k == 9) begin
        check($sformatf("boot_seg_c%0d", k), 32'(seg_n), 32'h7F);
        check($sformatf("boot_sel_c%0d", k), 32'(dig_sel_n), 32'hF);
      end else begin
        check($sformatf("boot_seg_c%0d", k), 32'(seg_n), 32'h40);
        check($sformatf("boot_sel_c%0d", k), 32'(dig_sel_n), 32'hE);
      end
    end

    // Two loads in one frame: latest wins, single ack, first value never shown.
    value_in = 16'h1111;
    load     = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    value_in = 16'h2222;
    load     = 1'b1;
    step();
    load = 1'b0;
    wait_ack("t3_ack", 40, cyc, seen79);
    check("t3_no_1111", 32'(seen79), 32'd0);
    v = '{16'h2222, 4'hF, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF};
    capture_frame("t3_frame", v);

    // Load on the commit cycle with nothing pending: no ack now, ack one frame later.
    for (int i = 1; i <= 31; i++) step();
    value_in = 16'h4B7E;
    load     = 1'b1;
    step();
    load = 1'b0;
    check("t4_no_ack_now", 32'(load_ack), 32'd0);
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i < 32) check($sformatf("t4_quiet_%0d", i), 32'(load_ack), 32'd0);
      else        check("t4_ack_next_frame", 32'(load_ack), 32'd1);
    end
    v = '{16'h4B7E, 4'hF, {7'h19, 7'h03, 7'h78, 7'h06}, 4'hF};
    capture_frame("t4_frame", v);

    for (int t = 0; t < 7; t++) begin
      digit_en = tbl[t].en;
      value_in = tbl[t].value;
      load     = 1'b1;
      step();
      load = 1'b0;
      wait_ack($sformatf("vec%0d_ack", t), 40, cyc, seen79);
      capture_frame($sformatf("vec%0d", t), tbl[t]);
    end

    // Reset mid-DRIVE drops the pending load and clears the shadow value.
    digit_en = 4'hF;
    value_in = 16'h7777;
    load     = 1'b1;
    step();
    load = 1'b0;
    cyc  = -1;
    for (int i = 1; i <= 20; i++) begin
      if (dig_sel_n != 4'hF) begin
        cyc = i;
        break;
      end
      step();
    end
    check("t6_found_drive", 32'(cyc > 0), 32'd1);
    reset = 1'b1;
    step();
    check("t6_rst_seg", 32'(seg_n), 32'h7F);
    check("t6_rst_sel", 32'(dig_sel_n), 32'hF);
    check("t6_rst_ack", 32'(load_ack), 32'd0);
    reset = 1'b0;
    bad  = 0;
    acks = 0;
    for (int i = 1; i <= 70; i++) begin
      step();
      if (load_ack === 1'b1) acks++;
      if (dig_sel_n != 4'hF && seg_n != 7'h40) bad++;
      if (LZB && dig_sel_n != 4'hF && dig_sel_n != 4'hE) bad++;
    end
    check("t6_pending_dropped", 32'(acks), 32'd0);
    check("t6_shadow_cleared", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
